rx_byte_decoder: RTL and testbench
==================================

// Module: rx_byte_decoder
// PURPOSE
//  Upstream feeder of the receive FIFO on the USB receive path. Takes the synchronized D+ line sample plus a
//  per-bit strobe from timing recovery; does NRZI decode, SYNC detect, bit unstuffing and LSB-first byte
//  assembly; writes each completed byte into the receive FIFO (w_data/w_enable) and flags packet errors.
// PARAMETERS
//  STUFF_LEN  6  consecutive decoded 1s after which the next bit is a stuffed bit
//  SYNC_BYTE  8'h80  decoded SYNC pattern (LSB-first assembly of KJKJKJKK)
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  rst        in   1  asynchronous, active-high reset
//  d_plus     in   1  synchronized D+ sample (1 = J / idle)
//  shift_en   in   1  one-cycle strobe: d_plus is valid for one bit period
//  eop        in   1  one-cycle strobe: end-of-packet detected on the line
//  fifo_full  in   1  receive FIFO full flag
//  w_data     out  8  assembled byte to FIFO
//  w_enable   out  1  one-cycle FIFO write strobe
//  rcving     out  1  high from SYNC match until packet ends
//  rx_error   out  1  sticky packet error; cleared on next SYNC match
// BEHAVIOUR
//  Reset (async): state=IDLE, prev_bit=1, sync_sr=8'hFF, shift_sr=0, bit_cnt=0, ones_cnt=0;
//   w_data=0, w_enable=0, rcving=0, rx_error=0.
//  NRZI: on shift_en, bit = (d_plus == prev_bit); prev_bit <= d_plus. Nothing changes without shift_en.
//  States: IDLE, RECV, EOPW (wait for eop after error).
//  IDLE: each decoded bit shifts into MSB of sync_sr (LSB-first). When the updated value == SYNC_BYTE:
//   -> RECV, rcving=1, rx_error=0, bit_cnt=0, ones_cnt=1 (SYNC trailing 1 starts the run).
//  RECV, on shift_en:
//   - ones_cnt==STUFF_LEN: stuffed bit. bit=0 -> discard, ones_cnt=0. bit=1 -> see CONFIGURATION.
//   - else bit shifts into shift_sr MSB; bit_cnt++; ones_cnt = bit ? ones_cnt+1 : 0.
//   - 8th data bit (bit_cnt 7->0): next cycle w_data=assembled byte, w_enable=1 for exactly one cycle.
//     If fifo_full is high in that strobe cycle: w_enable stays 0, byte dropped, rx_error=1, -> EOPW.
//  RECV, eop: bit_cnt==0 -> IDLE, rcving=0, clean end. bit_cnt!=0 -> partial byte: rx_error=1, -> IDLE.
//  EOPW: ignores data bits; on eop -> IDLE, rcving=0; rx_error stays 1.
//  eop coincident with shift_en: eop wins, that bit is discarded; a byte-completion strobe already
//   scheduled for this cycle still issues.
//  IDLE/EOPW exit: sync_sr<=8'hFF, prev_bit unchanged (tracks line continuously).
//  Latency: last bit's shift_en edge -> w_enable one clk later; w_data stable while w_enable high and held after.
//  rst mid-packet: all state to reset values immediately; no partial write issued.
// CONFIGURATION
//  RX_STUFF_ERR_EN defined: a 1 in the stuffed-bit slot is a stuff violation: rx_error=1, -> EOPW,
//   partial byte discarded.
//  RX_STUFF_ERR_EN undefined: the stuffed-bit slot is discarded unconditionally (ones_cnt=0), no error.
// TESTING
//  1 rst high then low, line idle J for 16 strobes -> rcving=0, w_enable never high, rx_error=0.
//  2 SYNC KJKJKJKK then NRZI of 8'hA5, 8'h3C, eop -> two w_enable pulses, w_data 8'hA5 then 8'h3C,
//    rcving falls after eop, rx_error=0.
//  3 SYNC then byte 8'hFF with stuffed 0 after 6th one (9 line bits) -> one write, w_data=8'hFF.
//  4 SYNC then seven decoded 1s: with RX_STUFF_ERR_EN rx_error=1 and no write until eop;
//    without it -> byte completes with stuffed slot dropped, rx_error=0.
//  5 fifo_full=1 while 8'h5A completes -> no w_enable, rx_error=1, further bits ignored until eop.
//  6 SYNC, 4 data bits, eop -> no write, rx_error=1, rcving=0; next clean packet clears rx_error.

Source files
------------

// File: rtl/rx_byte_decoder.sv
// rx_byte_decoder: USB receive-path front end.
// NRZI decode, SYNC detect, bit unstuffing and LSB-first byte assembly feeding the receive FIFO.
// Optional feature macro: RX_STUFF_ERR_EN -- when defined, a 1 in a stuffed-bit slot is treated
// as a stuff violation (error, wait for eop); when undefined the slot is silently dropped.
module rx_byte_decoder #(
  parameter int unsigned STUFF_LEN = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       shift_en,
  input  logic       eop,
  input  logic       fifo_full,
  output logic [7:0] w_data,
  output logic       w_enable,
  output logic       rcving,
  output logic       rx_error
);

  localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StEopw
  } state_t;

  state_t           state;
  logic             prev_bit;
  logic [7:0]       sync_sr;
  logic [7:0]       shift_sr;
  logic [2:0]       bit_cnt;
  logic [OnesW-1:0] ones_cnt;

  logic       dec_bit;
  logic [7:0] sync_next;
  logic [7:0] shift_next;
  logic       stuff_slot;

  // NRZI: no transition decodes to 1; both shifters fill LSB-first from the MSB end.
  always_comb begin
    dec_bit    = (d_plus == prev_bit);
    sync_next  = {dec_bit, sync_sr[7:1]};
    shift_next = {dec_bit, shift_sr[7:1]};
    stuff_slot = (ones_cnt == OnesW'(STUFF_LEN));
  end

  // Receive FSM with all datapath state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      prev_bit <= 1'b1;
      sync_sr  <= 8'hFF;
      shift_sr <= 8'h00;
      bit_cnt  <= 3'd0;
      ones_cnt <= '0;
      w_data   <= 8'h00;
      w_enable <= 1'b0;
      rcving   <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      w_enable <= 1'b0;
      // prev_bit follows the line in every state so decoding never loses phase.
      if (shift_en) begin
        prev_bit <= d_plus;
      end
      case (state)
        StIdle: begin
          if (shift_en) begin
            if (sync_next == SYNC_BYTE) begin
              state    <= StRecv;
              rcving   <= 1'b1;
              rx_error <= 1'b0;
              bit_cnt  <= 3'd0;
              // The trailing 1 of SYNC counts toward the first stuffing run.
              ones_cnt <= OnesW'(1);
              sync_sr  <= 8'hFF;
            end else begin
              sync_sr <= sync_next;
            end
          end
        end
        StRecv: begin
          // eop beats a coincident data bit; that bit is dropped.
          if (eop) begin
            state   <= StIdle;
            rcving  <= 1'b0;
            sync_sr <= 8'hFF;
            if (bit_cnt != 3'd0) begin
              rx_error <= 1'b1;
            end
          end else if (shift_en) begin
            if (stuff_slot) begin
              ones_cnt <= '0;
`ifdef RX_STUFF_ERR_EN
              if (dec_bit) begin
                rx_error <= 1'b1;
                state    <= StEopw;
              end
`endif
            end else begin
              shift_sr <= shift_next;
              bit_cnt  <= bit_cnt + 3'd1;
              ones_cnt <= dec_bit ? ones_cnt + OnesW'(1) : '0;
              if (bit_cnt == 3'd7) begin
                if (fifo_full) begin
                  rx_error <= 1'b1;
                  state    <= StEopw;
                end else begin
                  w_data   <= shift_next;
                  w_enable <= 1'b1;
                end
              end
            end
          end
        end
        StEopw: begin
          if (eop) begin
            state   <= StIdle;
            rcving  <= 1'b0;
            sync_sr <= 8'hFF;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_byte_decoder.sv
// tb_rx_byte_decoder: directed bench with a byte scoreboard for rx_byte_decoder.
module tb_rx_byte_decoder;

  localparam int StuffLen = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_plus;
  logic       shift_en;
  logic       eop;
  logic       fifo_full;
  logic [7:0] w_data;
  logic       w_enable;
  logic       rcving;
  logic       rx_error;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       line;
  int         tb_ones;
  logic       we_seen;

  rx_byte_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .d_plus   (d_plus),
    .shift_en (shift_en),
    .eop      (eop),
    .fifo_full(fifo_full),
    .w_data   (w_data),
    .w_enable (w_enable),
    .rcving   (rcving),
    .rx_error (rx_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && w_enable === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h expected=none", w_data);
      end
      if (exp_q.size() > 0) begin
        chk("w_data", {24'd0, w_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // One decoded bit on the line; we_seen is w_enable one clock after the strobe edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    if (!b) line = ~line;
    d_plus   = line;
    shift_en = 1'b1;
    @(negedge clk);
    shift_en = 1'b0;
    we_seen  = w_enable;
    repeat (2) @(negedge clk);
  endtask

  // Data bit with transmitter-side stuffing inserted as needed.
  task automatic send_data_bit(input logic b);
    if (tb_ones == StuffLen) begin
      send_bit(1'b0);
      tb_ones = 0;
    end
    send_bit(b);
    tb_ones = b ? tb_ones + 1 : 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic expect_write);
    if (expect_write) exp_q.push_back(v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    chk("write_latency", {31'd0, we_seen}, {31'd0, expect_write});
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 1;
  endtask

  task automatic pulse_eop();
    @(negedge clk);
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    line      = 1'b1;
    d_plus    = 1'b1;
    shift_en  = 1'b0;
    eop       = 1'b0;
    fifo_full = 1'b0;
    tb_ones   = 0;
    we_seen   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_w_enable", {31'd0, w_enable}, 32'd0);
    chk("rst_w_data", {24'd0, w_data}, 32'd0);
    chk("rst_rcving", {31'd0, rcving}, 32'd0);
    chk("rst_rx_error", {31'd0, rx_error}, 32'd0);
    rst = 1'b0;

    // Idle J line.
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    chk("idle_rcving", {31'd0, rcving}, 32'd0);
    chk("idle_rx_error", {31'd0, rx_error}, 32'd0);

    // Two clean bytes.
    send_sync();
    chk("sync_rcving", {31'd0, rcving}, 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    pulse_eop();
    chk("p2_rcving", {31'd0, rcving}, 32'd0);
    chk("p2_rx_error", {31'd0, rx_error}, 32'd0);
    chk("p2_w_data_held", {24'd0, w_data}, 32'h3C);
    chk("p2_drained", exp_q.size(), 32'd0);

    // 0xFF needs one stuffed zero.
    send_sync();
    send_byte(8'hFF, 1'b1);
    pulse_eop();
    chk("p3_rx_error", {31'd0, rx_error}, 32'd0);
    chk("p3_drained", exp_q.size(), 32'd0);

    // Seven decoded ones after SYNC: the sixth lands in the stuffed slot.
    send_sync();
`ifdef RX_STUFF_ERR_EN
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("p4_rx_error", {31'd0, rx_error}, 32'd1);
    chk("p4_rcving", {31'd0, rcving}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_eop();
    chk("p4_rx_error_held", {31'd0, rx_error}, 32'd1);
`else
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("p4_rx_error", {31'd0, rx_error}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_eop();
    chk("p4_rx_error_end", {31'd0, rx_error}, 32'd0);
`endif
    chk("p4_rcving_end", {31'd0, rcving}, 32'd0);
    chk("p4_drained", exp_q.size(), 32'd0);

    // FIFO full when the byte completes.
    send_sync();
    chk("p5_error_cleared", {31'd0, rx_error}, 32'd0);
    fifo_full = 1'b1;
    send_byte(8'h5A, 1'b0);
    chk("p5_rx_error", {31'd0, rx_error}, 32'd1);
    fifo_full = 1'b0;
    send_byte(8'h11, 1'b0);
    chk("p5_rcving", {31'd0, rcving}, 32'd1);
    pulse_eop();
    chk("p5_rcving_end", {31'd0, rcving}, 32'd0);
    chk("p5_rx_error_end", {31'd0, rx_error}, 32'd1);

    // Partial byte at eop, then a clean packet clears the error.
    send_sync();
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    pulse_eop();
    chk("p6_rx_error", {31'd0, rx_error}, 32'd1);
    chk("p6_rcving", {31'd0, rcving}, 32'd0);
    send_sync();
    chk("p6_error_cleared", {31'd0, rx_error}, 32'd0);
    send_byte(8'h96, 1'b1);
    pulse_eop();
    chk("p6_rx_error_end", {31'd0, rx_error}, 32'd0);

    // Reset mid-packet: no partial write, everything back to idle.
    send_sync();
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rcving", {31'd0, rcving}, 32'd0);
    chk("midrst_w_enable", {31'd0, w_enable}, 32'd0);
    @(negedge clk);
    line   = 1'b1;
    d_plus = 1'b1;
    rst    = 1'b0;
    send_sync();
    send_byte(8'h42, 1'b1);
    pulse_eop();
    chk("final_rx_error", {31'd0, rx_error}, 32'd0);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
